// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
//   - W_DATA      : datapath width
//   - MD_OP_*     : 3-bit operation codes presented on i_op
//   - md_state_e  : controller state encoding
//   - helpers     : op classification and operand magnitude
package muldiv_unit_pkg;

  localparam int W_DATA = 32;

  localparam logic [2:0] MD_OP_MULT  = 3'd0;
  localparam logic [2:0] MD_OP_MULTU = 3'd1;
  localparam logic [2:0] MD_OP_DIV   = 3'd2;
  localparam logic [2:0] MD_OP_DIVU  = 3'd3;
  localparam logic [2:0] MD_OP_MTHI  = 3'd4;
  localparam logic [2:0] MD_OP_MTLO  = 3'd5;

  typedef enum logic [2:0] {
    MD_IDLE    = 3'd0,
    MD_MUL     = 3'd1,
    MD_DIV_IT  = 3'd2,
    MD_DIV_FIX = 3'd3,
    MD_DONE    = 3'd4
  } md_state_e;

  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == MD_OP_MULT) || (op == MD_OP_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
  endfunction

  // Magnitude of a two's-complement value when use_sign is set, raw value otherwise.
  function automatic logic [W_DATA-1:0] abs_val(input logic [W_DATA-1:0] v, input logic use_sign);
    return (use_sign && v[W_DATA-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// Restoring radix-2 divider datapath on unsigned magnitudes.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_load         : capture dividend/divisor, clear remainder, arm step counter
//   i_step         : perform one quotient-bit iteration
//   i_dividend     : unsigned dividend
//   i_divisor      : unsigned divisor
//   o_q, o_r       : quotient / remainder after the final step
//   o_last         : the current step is the final one
module muldiv_unit_div_iter
  import muldiv_unit_pkg::*;
#(
  parameter int DIV_STEPS = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [W_DATA-1:0] i_dividend,
  input  logic [W_DATA-1:0] i_divisor,
  output logic [W_DATA-1:0] o_q,
  output logic [W_DATA-1:0] o_r,
  output logic              o_last
);

  localparam int CW = $clog2(DIV_STEPS);

  logic [W_DATA-1:0] r_q;
  logic [W_DATA-1:0] r_rem;
  logic [W_DATA-1:0] r_dvs;
  logic [CW-1:0]     r_cnt;

  logic [W_DATA:0]   w_rem_sh;
  logic [W_DATA-1:0] w_diff;
  logic              w_ge;

  // Remainder is kept below the divisor, so the 33-bit shifted value minus the
  // divisor always fits in 32 bits whenever the subtraction is taken.
  assign w_rem_sh = {r_rem, r_q[W_DATA-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_dvs});
  assign w_diff   = w_rem_sh[W_DATA-1:0] - r_dvs;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q   <= '0;
      r_rem <= '0;
      r_dvs <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_q   <= i_dividend;
      r_rem <= '0;
      r_dvs <= i_divisor;
      r_cnt <= CW'(DIV_STEPS - 1);
    end else if (i_step) begin
      r_q   <= {r_q[W_DATA-2:0], w_ge};
      r_rem <= w_ge ? w_diff : w_rem_sh[W_DATA-1:0];
      if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_q    = r_q;
  assign o_r    = r_rem;
  assign o_last = (r_cnt == '0);

endmodule

// File: rtl/muldiv_unit.sv
// EX-stage multiply/divide unit with architectural HI/LO.
//   i_clk, i_rst_n  : clock, async active-low reset
//   i_start, i_op   : valid muldiv/mthi/mtlo op in EX and its code
//   i_source_a/_b   : forwarded rs / rt operands
//   i_flush         : abort any in-flight op, drop a coincident start
//   o_stall         : freeze IF/ID/EX
//   o_done          : one-cycle pulse when HI/LO hold a new MULT/DIV result
//   o_hi, o_lo      : HI / LO registers
//
// state      | meaning
// MD_IDLE    | waiting for an op
// MD_MUL     | registering the 64-bit product into HI/LO
// MD_DIV_IT  | one restoring-divide iteration per cycle
// MD_DIV_FIX | sign correction / divide-by-zero result, write HI/LO
// MD_DONE    | result visible, done pulse; accepts a new op like IDLE
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int DIV_STEPS = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [2:0]        i_op,
  input  logic [W_DATA-1:0] i_source_a,
  input  logic [W_DATA-1:0] i_source_b,
  input  logic              i_flush,
  output logic              o_stall,
  output logic              o_done,
  output logic [W_DATA-1:0] o_hi,
  output logic [W_DATA-1:0] o_lo
);

  md_state_e         r_state, w_state_nxt;
  logic [W_DATA-1:0] r_a, r_b, r_hi, r_lo;
  logic              r_signed;

  logic              w_idle_like, w_accept_md, w_op_signed, w_load, w_last;
  logic [W_DATA-1:0] w_q, w_r, w_q_fix, w_r_fix;
  logic [63:0]       w_ma, w_mb, w_prod;

  assign w_idle_like = (r_state == MD_IDLE) || (r_state == MD_DONE);
  assign w_accept_md = i_start && w_idle_like && (is_mul_op(i_op) || is_div_op(i_op));
  assign w_op_signed = (i_op == MD_OP_MULT) || (i_op == MD_OP_DIV);
  assign w_load      = w_accept_md && is_div_op(i_op) && !i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= MD_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_stall     = w_accept_md;
    o_done      = 1'b0;
    case (r_state)
      MD_IDLE, MD_DONE: begin
        o_done      = (r_state == MD_DONE);
        w_state_nxt = MD_IDLE;
        if (i_start && is_mul_op(i_op)) w_state_nxt = MD_MUL;
        if (i_start && is_div_op(i_op)) w_state_nxt = MD_DIV_IT;
      end
      MD_MUL: begin
        o_stall     = 1'b1;
        w_state_nxt = MD_DONE;
      end
      MD_DIV_IT: begin
        o_stall = 1'b1;
        if (w_last) w_state_nxt = MD_DIV_FIX;
      end
      MD_DIV_FIX: begin
        o_stall     = 1'b1;
        w_state_nxt = MD_DONE;
      end
      default: w_state_nxt = MD_IDLE;
    endcase
    if (i_flush) w_state_nxt = MD_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
    end else if (w_accept_md && !i_flush) begin
      r_a      <= i_source_a;
      r_b      <= i_source_b;
      r_signed <= w_op_signed;
    end
  end

  muldiv_unit_div_iter #(.DIV_STEPS(DIV_STEPS)) u_div_iter (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_load),
    .i_step     (r_state == MD_DIV_IT),
    .i_dividend (abs_val(i_source_a, w_op_signed)),
    .i_divisor  (abs_val(i_source_b, w_op_signed)),
    .o_q        (w_q),
    .o_r        (w_r),
    .o_last     (w_last)
  );

  // Low 64 bits of a 64x64 product of extended operands equal the exact
  // 32x32 signed or unsigned product.
  assign w_ma   = {{32{r_signed & r_a[W_DATA-1]}}, r_a};
  assign w_mb   = {{32{r_signed & r_b[W_DATA-1]}}, r_b};
  assign w_prod = w_ma * w_mb;

  // Divide by zero bypasses the sign fix and returns the raw dividend in HI.
  always_comb begin
    w_q_fix = w_q;
    w_r_fix = w_r;
    if (r_b == '0) begin
      w_q_fix = '1;
      w_r_fix = r_a;
    end else begin
      if (r_signed && (r_a[W_DATA-1] ^ r_b[W_DATA-1])) w_q_fix = -w_q;
      if (r_signed && r_a[W_DATA-1])                   w_r_fix = -w_r;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (!i_flush) begin
      if (i_start && w_idle_like && (i_op == MD_OP_MTHI)) r_hi <= i_source_a;
      if (i_start && w_idle_like && (i_op == MD_OP_MTLO)) r_lo <= i_source_a;
      if (r_state == MD_MUL) {r_hi, r_lo} <= w_prod;
      if (r_state == MD_DIV_FIX) begin
        r_lo <= w_q_fix;
        r_hi <= w_r_fix;
      end
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk, rst_n, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        stall, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  muldiv_unit #(.DIV_STEPS(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op),
    .i_source_a(a), .i_source_b(b), .i_flush(flush),
    .o_stall(stall), .o_done(done), .o_hi(hi), .o_lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural result {hi,lo} from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] xa, input logic [31:0] xb);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(xa));
    sb = longint'($signed(xb));
    ua = {32'd0, xa};
    ub = {32'd0, xb};
    case (o)
      MD_OP_MULT:  return sa * sb;
      MD_OP_MULTU: return ua * ub;
      MD_OP_DIV: begin
        if (xb == 0) return {xa, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      MD_OP_DIVU: begin
        if (xb == 0) return {xa, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Entered 2 time units after a rising edge; for MULT/DIV returns in the done cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] xa, input logic [31:0] xb);
    logic [63:0] res;
    int lat;
    bit md;
    md  = (o <= MD_OP_DIVU);
    lat = (o == MD_OP_MULT || o == MD_OP_MULTU) ? 2 : 34;
    op = o; a = xa; b = xb; start = 1'b1;
    #1;
    chk("stall_issue", {63'd0, stall}, {63'd0, md});
    @(posedge clk); #1;
    start = 1'b0;
    op = 3'($urandom_range(0, 5)); a = $urandom; b = $urandom;
    #1;
    if (!md) begin
      if (o == MD_OP_MTHI) m_hi = xa; else m_lo = xa;
      chk("mt_hi", {32'd0, hi}, {32'd0, m_hi});
      chk("mt_lo", {32'd0, lo}, {32'd0, m_lo});
      chk("mt_done", {63'd0, done}, 64'd0);
      return;
    end
    res = model(o, xa, xb);
    for (int k = 1; k <= lat; k++) begin
      if (k > 1) begin @(posedge clk); #2; end
      chk($sformatf("done@T+%0d", k), {63'd0, done}, {63'd0, (k == lat)});
      chk($sformatf("stall@T+%0d", k), {63'd0, stall}, {63'd0, (k < lat)});
    end
    m_hi = res[63:32];
    m_lo = res[31:0];
    chk($sformatf("hi_op%0d", o), {32'd0, hi}, {32'd0, m_hi});
    chk($sformatf("lo_op%0d", o), {32'd0, lo}, {32'd0, m_lo});
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    bit seen;

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    #3;
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_done",  {63'd0, done},  64'd0);
    chk("rst_hi",    {32'd0, hi},    64'd0);
    chk("rst_lo",    {32'd0, lo},    64'd0);
    #4 rst_n = 1'b1;
    @(posedge clk); #2;

    run_op(MD_OP_MULT,  32'hFFFF_FFFF, 32'd2);
    @(posedge clk); #2;
    run_op(MD_OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    @(posedge clk); #2;
    run_op(MD_OP_DIV,   32'hFFFF_FFF9, 32'd2);
    run_op(MD_OP_DIVU,  32'd100,       32'd7);
    run_op(MD_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    run_op(MD_OP_DIVU,  32'd5,         32'd0);
    run_op(MD_OP_DIV,   32'hFFFF_FFF7, 32'd0);
    run_op(MD_OP_MULT,  32'h8000_0000, 32'h8000_0000);
    @(posedge clk); #2;

    // Flush mid-divide
    op = MD_OP_DIV; a = 32'd100; b = 32'd3; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2 flush = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0;
    #1;
    chk("flush_stall", {63'd0, stall}, 64'd0);
    chk("flush_done",  {63'd0, done},  64'd0);
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #2;
      seen = seen | done;
    end
    chk("flush_no_done", {63'd0, seen}, 64'd0);
    chk("flush_hi", {32'd0, hi}, {32'd0, m_hi});
    chk("flush_lo", {32'd0, lo}, {32'd0, m_lo});
    run_op(MD_OP_MTLO, 32'h0000_1234, 32'd0);

    // Start coincident with flush is dropped
    op = MD_OP_MTHI; a = 32'hDEAD_BEEF; start = 1'b1; flush = 1'b1;
    @(posedge clk); #2;
    start = 1'b0; flush = 1'b0;
    #1;
    chk("flush_drop_hi", {32'd0, hi}, {32'd0, m_hi});
    @(posedge clk); #2;

    // Randomised ops, some back-to-back from the done cycle
    for (int n = 0; n < 26; n++) begin
      ro = 3'($urandom_range(0, 5));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'($urandom_range(0, 9));
        1:       rb = -32'($urandom_range(1, 9));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 2) == 0) begin @(posedge clk); #2; end
      run_op(ro, ra, rb);
    end
    run_op(MD_OP_MTHI, 32'hCAFE_0001, 32'd0);

    // Async reset mid-divide
    run_op(MD_OP_MTLO, 32'h5555_AAAA, 32'd0);
    op = MD_OP_DIVU; a = 32'd1000; b = 32'd9; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #4 rst_n = 1'b0;
    #1;
    chk("arst_stall", {63'd0, stall}, 64'd0);
    chk("arst_done",  {63'd0, done},  64'd0);
    chk("arst_hi",    {32'd0, hi},    64'd0);
    chk("arst_lo",    {32'd0, lo},    64'd0);
    m_hi = '0; m_lo = '0;
    #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #2;
      seen = seen | done | stall;
    end
    chk("arst_idle", {63'd0, seen}, 64'd0);
    run_op(MD_OP_MULTU, 32'd12345, 32'd6789);
    run_op(MD_OP_DIV, 32'd7, 32'hFFFF_FFFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
